// File: rtl/isa_pkg.sv
// Shared ISA definitions for the pipeline front end.
//   - instruction word field positions (opcode / src / dst)
//   - NOP opcode used for pipeline bubbles
//   - two-word instruction predicate (opcode[5:4] == 2'b11)
//   - fetch FSM state encoding
//   - default address / word widths
package isa_pkg;

   localparam int unsigned DEF_PC_W = 16;
   localparam int unsigned DEF_W    = 16;

   localparam int unsigned OPC_HI = 15;
   localparam int unsigned OPC_LO = 10;
   localparam int unsigned SRC_HI = 9;
   localparam int unsigned SRC_LO = 7;
   localparam int unsigned DST_HI = 6;
   localparam int unsigned DST_LO = 4;

   localparam logic [5:0] NOP_OPCODE = 6'b00_0000;

   typedef enum logic {
      ST_OP  = 1'b0,
      ST_IMM = 1'b1
   } fetch_state_e;

   function automatic logic is_two_word(input logic [5:0] opcode);
      return (opcode[5:4] == 2'b11);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears to bubble)
//   en              load enable (deasserted by a stall)
//   clr             synchronous clear-to-bubble; overrides en
//   d_*             next instruction fields from fetch
//   q_*             registered fields driving decode
module if_id_reg
   import isa_pkg::*;
#(
   parameter int unsigned PC_W = DEF_PC_W,
   parameter int unsigned W    = DEF_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            d_valid,
   input  logic [5:0]      d_opcode,
   input  logic [2:0]      d_src,
   input  logic [2:0]      d_dst,
   input  logic [W-1:0]    d_imm,
   input  logic [PC_W-1:0] d_pc_next,
   output logic            q_valid,
   output logic [5:0]      q_opcode,
   output logic [2:0]      q_src,
   output logic [2:0]      q_dst,
   output logic [W-1:0]    q_imm,
   output logic [PC_W-1:0] q_pc_next
);

   logic            valid_q,   valid_d;
   logic [5:0]      opcode_q,  opcode_d;
   logic [2:0]      src_q,     src_d;
   logic [2:0]      dst_q,     dst_d;
   logic [W-1:0]    imm_q,     imm_d;
   logic [PC_W-1:0] pc_next_q, pc_next_d;

   always_comb begin
      valid_d   = valid_q;
      opcode_d  = opcode_q;
      src_d     = src_q;
      dst_d     = dst_q;
      imm_d     = imm_q;
      pc_next_d = pc_next_q;
      if (clr) begin
         valid_d   = 1'b0;
         opcode_d  = NOP_OPCODE;
         src_d     = '0;
         dst_d     = '0;
         imm_d     = '0;
         pc_next_d = '0;
      end else if (en) begin
         valid_d   = d_valid;
         opcode_d  = d_opcode;
         src_d     = d_src;
         dst_d     = d_dst;
         imm_d     = d_imm;
         pc_next_d = d_pc_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         opcode_q  <= NOP_OPCODE;
         src_q     <= '0;
         dst_q     <= '0;
         imm_q     <= '0;
         pc_next_q <= '0;
      end else begin
         valid_q   <= valid_d;
         opcode_q  <= opcode_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         imm_q     <= imm_d;
         pc_next_q <= pc_next_d;
      end
   end

   always_comb begin
      q_valid   = valid_q;
      q_opcode  = opcode_q;
      q_src     = src_q;
      q_dst     = dst_q;
      q_imm     = imm_q;
      q_pc_next = pc_next_q;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads 16-bit words from instruction
// memory, assembles one- and two-word instructions and feeds IF/ID.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_addr / imem_data instruction memory address (= PC) and same-cycle data
//   stall                 hold PC, FSM, holding regs and IF/ID
//   flush                 bubble into IF/ID, PC still advances
//   br_taken / br_target  redirect PC (implies flush)
//   id_*                  IF/ID register outputs to decode
module fetch_stage
   import isa_pkg::*;
#(
   parameter int unsigned     PC_W     = DEF_PC_W,
   parameter int unsigned     W        = DEF_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   input  logic [W-1:0]    imem_data,
   input  logic            stall,
   input  logic            flush,
   input  logic            br_taken,
   input  logic [PC_W-1:0] br_target,
   output logic            id_valid,
   output logic [5:0]      id_opcode,
   output logic [2:0]      id_src,
   output logic [2:0]      id_dst,
   output logic [W-1:0]    id_imm,
   output logic [PC_W-1:0] id_pc_next
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d, pc_inc;
   logic [5:0]      hold_opcode_q, hold_opcode_d;
   logic [2:0]      hold_src_q,    hold_src_d;
   logic [2:0]      hold_dst_q,    hold_dst_d;

   logic [5:0]      w_opcode;
   logic [2:0]      w_src;
   logic [2:0]      w_dst;

   logic            nxt_valid;
   logic [5:0]      nxt_opcode;
   logic [2:0]      nxt_src;
   logic [2:0]      nxt_dst;
   logic [W-1:0]    nxt_imm;
   logic [PC_W-1:0] nxt_pc_next;
   logic            kill;

   always_comb begin
      w_opcode = imem_data[OPC_HI:OPC_LO];
      w_src    = imem_data[SRC_HI:SRC_LO];
      w_dst    = imem_data[DST_HI:DST_LO];
      // Wraps modulo 2^PC_W by truncation.
      pc_inc   = pc_q + PC_W'(1);
      kill     = br_taken | flush;
      imem_addr = pc_q;
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      hold_opcode_d = hold_opcode_q;
      hold_src_d    = hold_src_q;
      hold_dst_d    = hold_dst_q;
      nxt_valid     = 1'b0;
      nxt_opcode    = NOP_OPCODE;
      nxt_src       = '0;
      nxt_dst       = '0;
      nxt_imm       = '0;
      nxt_pc_next   = '0;

      if (br_taken) begin
         pc_d    = br_target;
         state_d = ST_OP;
      end else if (flush) begin
         // The killed word is not re-fetched.
         pc_d    = pc_inc;
         state_d = ST_OP;
      end else if (!stall) begin
         pc_d = pc_inc;
         if (state_q == ST_IMM) begin
            nxt_valid   = 1'b1;
            nxt_opcode  = hold_opcode_q;
            nxt_src     = hold_src_q;
            nxt_dst     = hold_dst_q;
            nxt_imm     = imem_data;
            nxt_pc_next = pc_inc;
            state_d     = ST_OP;
         end else if (is_two_word(w_opcode)) begin
            // First half: park the fields, emit a bubble this cycle.
            hold_opcode_d = w_opcode;
            hold_src_d    = w_src;
            hold_dst_d    = w_dst;
            state_d       = ST_IMM;
         end else begin
            nxt_valid   = 1'b1;
            nxt_opcode  = w_opcode;
            nxt_src     = w_src;
            nxt_dst     = w_dst;
            nxt_pc_next = pc_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_OP;
         pc_q          <= RESET_PC;
         hold_opcode_q <= '0;
         hold_src_q    <= '0;
         hold_dst_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         hold_opcode_q <= hold_opcode_d;
         hold_src_q    <= hold_src_d;
         hold_dst_q    <= hold_dst_d;
      end
   end

   // Clear beats enable, so a redirect or flush still bubbles IF/ID under stall.
   if_id_reg #(
      .PC_W (PC_W),
      .W    (W)
   ) u_if_id (
      .clk       (clk),
      .rst       (rst),
      .en        (!stall),
      .clr       (kill),
      .d_valid   (nxt_valid),
      .d_opcode  (nxt_opcode),
      .d_src     (nxt_src),
      .d_dst     (nxt_dst),
      .d_imm     (nxt_imm),
      .d_pc_next (nxt_pc_next),
      .q_valid   (id_valid),
      .q_opcode  (id_opcode),
      .q_src     (id_src),
      .q_dst     (id_dst),
      .q_imm     (id_imm),
      .q_pc_next (id_pc_next)
   );

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage pipeline: owns the PC, reads 16-bit words from instruction memory, assembles one- and two-word instructions, and drives the IF/ID pipeline register that feeds decode (opcode, src, dst fields plus immediate). Handles stall (hold), flush (bubble), and branch redirect from later stages.

## Interface
- PC_W, 16, PC / instruction-memory address width; PC wraps modulo 2^PC_W
- W, 16, instruction and immediate word width
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  PC_W  word address to instruction memory (= PC)
- imem_data  in  W  word at imem_addr, combinational same-cycle read
- stall  in  1  hazard unit: hold PC, FSM and IF/ID contents
- flush  in  1  kill instruction in flight; IF/ID becomes bubble
- br_taken  in  1  redirect PC to br_target (implies flush)
- br_target  in  PC_W  redirect address
- id_valid  out  1  IF/ID holds a real instruction
- id_opcode  out  6  instruction bits [15:10]
- id_src  out  3  bits [9:7]
- id_dst  out  3  bits [6:4]
- id_imm  out  W  second word of two-word instruction, else 0
- id_pc_next  out  PC_W  address following the instruction (for call/return)

## Operation
- Word format: opcode [15:10], src [9:7], dst [6:4], [3:0] ignored.
- Two-word instruction: opcode[5:4] == 2'b11; next word is immediate.
- FSM states: OP, IMM. Reset → OP.
- OP, imem_data single-word: IF/ID ← fields, imm 0, valid 1; PC ← PC+1; stay OP.
- OP, two-word: latch fields in holding regs; IF/ID ← bubble (valid 0, opcode 0 = NOP, all fields 0); PC ← PC+1; → IMM.
- IMM: IF/ID ← held fields, imm = imem_data, valid 1, pc_next = PC+1; PC ← PC+1; → OP.
- stall (no flush/br): PC, state, holding regs, IF/ID all unchanged.
- flush: IF/ID ← bubble; state → OP; PC ← PC+1 unless br_taken (no re-fetch of the killed word).
- br_taken: IF/ID ← bubble; PC ← br_target; state → OP; partial two-word instruction discarded.
- Priority: rst > br_taken > flush > stall > normal.
- PC arithmetic modulo 2^PC_W: PC = all-ones advances to 0; a two-word instruction straddling wrap takes imm from address 0.

## Timing
- Reset values: PC = RESET_PC, state OP, id_valid 0, id_opcode 0, id_src 0, id_dst 0, id_imm 0, id_pc_next 0, holding regs 0; imem_addr = RESET_PC immediately.
- Latency: word at PC in cycle n appears on id_* after edge n (visible cycle n+1); two-word instruction visible one cycle after its immediate is fetched, preceded by one bubble cycle.
- Throughput: 1 instruction/cycle single-word, 1 per 2 cycles two-word.
- br_taken at edge n: imem_addr = br_target in cycle n+1; first redirected instruction valid in cycle n+2.
- Reset asserted mid-IMM: holding instruction lost, no valid output until after release.
- stall and br_taken same cycle: redirect wins; stall ignored that cycle.

## Structure
- Shared package isa_pkg: opcode field positions, NOP opcode (6'b0), two-word predicate, FSM state encoding, default widths; also used by Control_Unit and decode.
- One sub-module: if_id_reg (enable = !stall, synchronous clear-to-bubble on flush, async reset), instantiated by fetch_stage; PC, FSM and holding regs stay in fetch_stage.

## Test plan
- Reset release, memory [0]=0x0450, [1]=0x0890: cycle 1 id_opcode 1, src 0, dst 5, valid 1, pc_next 1; cycle 2 opcode 2, src 1, dst 1.
- Two-word: [0]=0xC0A0, [1]=0x1234: cycle 1 valid 0; cycle 2 valid 1, opcode 0x30, src 1, dst 2, imm 0x1234, pc_next 2.
- Stall 3 cycles while PC=4: imem_addr stays 4, id_* unchanged, resumes with [4] on release.
- br_taken, br_target 0x0100 while in IMM: bubble out, partial discarded, imem_addr 0x0100 next cycle, [0x100] valid cycle after.
- flush + stall same cycle at PC=7: bubble, PC advances to 8; PC=0xFFFF single-word → next PC 0x0000.
- rst pulse mid-IMM (asynchronous, between edges): outputs zero immediately, PC = RESET_PC, state OP.
